la_capture_mux: RTL

//  Parametrised logic-analyzer source selector with registered output and capture modes.

---
 rtl/la_capture_mux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/la_capture_mux.sv
// Logic-analyzer probe selector: picks one of NUM_CH probe buses and streams, decimates,
// trigger-captures or freezes it onto a registered output. Config arrives via valid/ready.
module la_capture_mux #(
   parameter int NUM_CH = 13,
   parameter int WIDTH  = 128,
   parameter int SEL_W  = $clog2(NUM_CH),
   parameter int DIV_W  = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] la_dat [NUM_CH-1:0],
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic [1:0]       cfg_mode,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic [WIDTH-1:0] cfg_match,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             arm,
   output logic [WIDTH-1:0] la_out,
   output logic             la_out_valid,
   output logic             triggered,
   output logic             sel_err
);

   typedef enum logic [1:0] {M_LIVE, M_DECIM, M_TRIG, M_FREEZE} mode_e;
   typedef enum logic [1:0] {S_RUN, S_SWITCH, S_ARMED, S_HELD} state_e;

   localparam logic [SEL_W:0]   NUM_CH_W = NUM_CH[SEL_W:0];
   localparam logic [DIV_W-1:0] CNT_ONE  = 1;

   state_e           state, state_nxt;
   mode_e            mode_q;
   logic [SEL_W-1:0] sel_q;
   logic [DIV_W-1:0] div_q, counter, cnt_nxt;
   logic [WIDTH-1:0] mask_q, match_q, samp, samp_d;
   logic [SEL_W-1:0] src_sel;
   logic             accept, hit, run_act, upd, trig_set, trig_clr;

   assign cfg_ready = (state != S_SWITCH);
   assign accept    = cfg_valid & cfg_ready;
   assign hit       = ((samp & mask_q) == (match_q & mask_q));
   // The switch cycle already performs the first run-mode update, so new data shows right after it.
   assign run_act   = (state == S_RUN) || ((state == S_SWITCH) && (mode_q != M_TRIG));

   // On accept the sampler reads the requested channel so it is refilled during S_SWITCH.
   assign src_sel = accept ? cfg_sel : sel_q;
   assign samp_d  = ({1'b0, src_sel} < NUM_CH_W) ? la_dat[src_sel] : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_RUN;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_nxt = state;
      upd       = 1'b0;
      cnt_nxt   = counter;
      trig_set  = 1'b0;
      trig_clr  = 1'b0;
      if (accept) begin
         state_nxt = S_SWITCH;
      end else begin
         case (state)
            S_SWITCH: state_nxt = (mode_q == M_TRIG) ? S_ARMED : S_RUN;
            S_ARMED: begin
               if (hit) begin
                  state_nxt = S_HELD;
                  upd       = 1'b1;
                  trig_set  = 1'b1;
               end
            end
            S_HELD: begin
               if (arm) begin
                  state_nxt = S_ARMED;
                  trig_clr  = 1'b1;
               end
            end
            default: ;
         endcase
         if (run_act) begin
            case (mode_q)
               M_LIVE:  upd = 1'b1;
               M_DECIM: begin
                  if (counter == div_q) begin
                     upd     = 1'b1;
                     cnt_nxt = '0;
                  end else begin
                     cnt_nxt = counter + CNT_ONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sel_q        <= '0;
         mode_q       <= M_LIVE;
         div_q        <= '0;
         mask_q       <= '0;
         match_q      <= '0;
         counter      <= '0;
         samp         <= '0;
         la_out       <= '0;
         la_out_valid <= 1'b0;
         triggered    <= 1'b0;
         sel_err      <= 1'b0;
      end else begin
         samp <= samp_d;
         if (accept) begin
            sel_q        <= cfg_sel;
            mode_q       <= mode_e'(cfg_mode);
            div_q        <= cfg_div;
            mask_q       <= cfg_mask;
            match_q      <= cfg_match;
            sel_err      <= ({1'b0, cfg_sel} >= NUM_CH_W);
            counter      <= '0;
            triggered    <= 1'b0;
            la_out_valid <= 1'b0;
         end else begin
            counter      <= cnt_nxt;
            la_out_valid <= upd;
            if (upd) la_out <= samp;
            if (trig_set)      triggered <= 1'b1;
            else if (trig_clr) triggered <= 1'b0;
         end
      end
   end

endmodule
